// File: rtl/timer_555_pkg.sv
// Shared types and constants for the 555-style timer array.
package timer_555_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_e;

   localparam logic MODE_ASTABLE = 1'b0;
   localparam logic MODE_MONO    = 1'b1;

endpackage

// File: rtl/timer_555_channel.sv
// One timer channel: IDLE/LOW/HIGH FSM with a phase down-counter.
// Handshake-free: trig is a level input whose rising edge is detected against the previous clock sample.
module timer_555_channel
   import timer_555_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             trig,
   input  logic [CNT_W-1:0] on_cnt,
   input  logic [CNT_W-1:0] off_cnt,
   output state_e           state,
   output logic             pulse,
   output logic             busy,
   output logic             cycle_done
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             trig_prev_q, trig_prev_d;
   logic             pulse_q, pulse_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [CNT_W-1:0] on_load;
   logic [CNT_W-1:0] off_load;
   logic             trig_rise;

   // Counter holds "cycles remaining after this one"; a count of 0 behaves like 1.
   assign on_load   = (on_cnt  == '0) ? '0 : on_cnt  - CNT_ONE;
   assign off_load  = (off_cnt == '0) ? '0 : off_cnt - CNT_ONE;
   assign trig_rise = trig & ~trig_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mode_q      <= MODE_ASTABLE;
         trig_prev_q <= 1'b0;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         trig_prev_q <= trig_prev_d;
         pulse_q     <= pulse_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // mode_q is latched on leaving IDLE so a live mode change waits for the next IDLE.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      trig_prev_d = trig;
      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mode == MODE_ASTABLE) begin
                  state_d = LOW;
                  cnt_d   = off_load;
                  mode_d  = MODE_ASTABLE;
               end else if (trig_rise) begin
                  state_d = HIGH;
                  cnt_d   = on_load;
                  mode_d  = MODE_MONO;
               end
            end
            LOW: begin
               if (cnt_q == '0) begin
                  state_d = HIGH;
                  cnt_d   = on_load;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            HIGH: begin
               if (cnt_q == '0) begin
                  if (mode_q == MODE_MONO) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = LOW;
                     cnt_d   = off_load;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      pulse_d = (state_d == HIGH);
      busy_d  = (state_d != IDLE);
      done_d  = en && (state_q == HIGH) && (cnt_q == '0);
   end

   assign state      = state_q;
   assign pulse      = pulse_q;
   assign busy       = busy_q;
   assign cycle_done = done_q;

endmodule

// File: rtl/timer_555_array.sv
// Array of independent 555-style timer channels; pure port slicing around timer_555_channel.
module timer_555_array
   import timer_555_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       mode,
   input  logic [CHANNELS-1:0]       trig,
   input  logic [CHANNELS*CNT_W-1:0] on_cnt,
   input  logic [CHANNELS*CNT_W-1:0] off_cnt,
   output logic [CHANNELS-1:0]       pulse,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS-1:0]       cycle_done
);

   // Per-channel FSM state, kept visible for hierarchical probes and bound checkers.
   state_e ch_state [CHANNELS];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      timer_555_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .en         (en[i]),
         .mode       (mode[i]),
         .trig       (trig[i]),
         .on_cnt     (on_cnt[i*CNT_W +: CNT_W]),
         .off_cnt    (off_cnt[i*CNT_W +: CNT_W]),
         .state      (ch_state[i]),
         .pulse      (pulse[i]),
         .busy       (busy[i]),
         .cycle_done (cycle_done[i])
      );
   end

endmodule

// File: doc/timer_555_array.md
TIMER_555_ARRAY -- requirements
Module: timer_555_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of each phase-length count in clock cycles.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  CHANNELS  per-channel enable, level-sensitive.
REQ-006 SHALL have port mode  input  CHANNELS  per-channel mode: 0 = astable, 1 = monostable.
REQ-007 SHALL have port trig  input  CHANNELS  per-channel monostable trigger, synchronous to clk, rising-edge detected.
REQ-008 SHALL have port on_cnt  input  CHANNELS*CNT_W  per-channel high-phase length; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port off_cnt  input  CHANNELS*CNT_W  per-channel low-phase length; same packing as on_cnt.
REQ-010 SHALL have port pulse  output  CHANNELS  per-channel timer output, registered.
REQ-011 SHALL have port busy  output  CHANNELS  per-channel: high whenever the channel is not IDLE.
REQ-012 SHALL have port cycle_done  output  CHANNELS  per-channel one-cycle strobe at the end of every high phase.

Function
REQ-013 Each channel SHALL implement an FSM with states IDLE, LOW, HIGH and a CNT_W-bit down-counter.
REQ-014 Phase length SHALL be sampled from on_cnt/off_cnt on the edge that enters the phase; later input changes SHALL NOT affect the running phase.
REQ-015 A sampled count of 0 SHALL be treated as 1; a phase of count N SHALL hold its pulse level for exactly N clock cycles.
REQ-016 Astable: IDLE with en=1 and mode=0 SHALL enter LOW on the next edge; LOW SHALL go to HIGH after off_cnt cycles; HIGH SHALL go to LOW after on_cnt cycles. Period = on+off cycles.
REQ-017 Monostable: IDLE with en=1, mode=1 and a trig rising edge (trig=1, previous sample 0) SHALL enter HIGH on the next edge; after on_cnt cycles it SHALL return to IDLE.
REQ-018 Trig edges arriving while a monostable channel is in HIGH SHALL be ignored (non-retriggerable), and SHALL NOT be queued.
REQ-019 pulse SHALL be 1 in HIGH and 0 in IDLE and LOW.
REQ-020 cycle_done SHALL be 1 for exactly the one cycle following the last cycle of every HIGH phase, in both modes.
REQ-021 Deasserting en in any state SHALL force IDLE on the next edge, with pulse=0 and no cycle_done strobe.
REQ-022 A mode change while a channel is not IDLE SHALL take effect only after the channel next passes through IDLE.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL NOT interact.

Reset
REQ-024 While rst_n=0, every channel SHALL be in IDLE with counter=0, pulse=0, busy=0, cycle_done=0, and trig edge history=0, asynchronously.
REQ-025 Reset deassertion SHALL be followed by normal operation from the first rising edge; an astable channel with en=1 SHALL start its LOW phase on that edge.

Structure
REQ-026 A shared package timer_555_pkg SHALL hold the state enumeration (IDLE, LOW, HIGH) and the mode constants MODE_ASTABLE=0 and MODE_MONO=1.
REQ-027 The top SHALL instantiate CHANNELS copies of one sub-module, timer_555_channel, via a generate loop, and SHALL contain no other logic than port slicing.

Verification
REQ-028 Astable: ch0 en=1, on=3, off=2 -> pulse pattern 0,0,1,1,1 repeating (period 5), cycle_done once per period.
REQ-029 Monostable: ch1 mode=1, on=4, trig pulse, second trig 2 cycles later -> single 4-cycle high, busy high for 4 cycles, one cycle_done.
REQ-030 Zero count: on=0, off=0 astable -> pulse toggles every cycle (period 2).
REQ-031 Mid-phase disable: astable on=10, en dropped in cycle 5 of HIGH -> pulse=0 next edge, busy=0, no cycle_done.
REQ-032 Async reset mid-HIGH: rst_n low between edges -> pulse, busy, cycle_done 0 immediately; restart begins with LOW.
REQ-033 Count change during phase: off=5 running, off_cnt changed to 1 at cycle 2 -> current LOW lasts 5 cycles, next LOW lasts 1.
